// File: rtl/llc_update_ctrl.sv
// llc_update_ctrl: sequencer for the LLC update (write-back) stage.
// Decides each cycle whether the update stage fires for the FIFO head. For
// reset/flush packets it first walks every set, then fires the final update.
// Optional build macro: LLC_UPDATE_STARVE_GUARD_EN (starvation guard that
// asks the lookup stage to back off after MAX_DEFER deferred cycles).
module llc_update_ctrl #(
  parameter int SET_BITS  = 4,
  parameter int MAX_DEFER = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_empty_update,
  input  logic                head_is_rst,
  input  logic                head_is_flush,
  input  logic                rd_conflict,
  input  logic                llc_rst_tb_done_ready_int,
  output logic                update_en,
  output logic                sweep_wr_en,
  output logic [SET_BITS-1:0] sweep_set,
  output logic                busy,
  output logic                hold_lookup
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic [SET_BITS-1:0] LAST_SET = '1;

  state_e              state_q, state_d;
  logic [SET_BITS-1:0] set_q, set_d;
  logic                upd_raw;
  logic                swe_raw;
  logic                head_special;

  assign head_special = head_is_rst | head_is_flush;

  // Next-state, sweep counter and raw port-use decisions.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    set_d   = set_q;
    upd_raw = 1'b0;
    swe_raw = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_update) begin
          if (head_special) begin
            state_d = ST_SWEEP;
            set_d   = '0;
          end else if (!rd_conflict) begin
            upd_raw = 1'b1;
          end
        end
      end
      ST_SWEEP: begin
        // The lookup stage owns the port on a conflict; the counter holds.
        if (!rd_conflict) begin
          swe_raw = 1'b1;
          set_d   = set_q + 1'b1;
          if (set_q == LAST_SET) begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        if (llc_rst_tb_done_ready_int && !rd_conflict) begin
          upd_raw = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        set_d   = '0;
      end
    endcase
  end

  // State and sweep-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
    end
  end

  // NOTE: the port strobes are combinational, so they are masked during the
  // reset cycle itself; otherwise a waiting plain head could fire while rst=1.
  assign update_en   = upd_raw & ~rst;
  assign sweep_wr_en = swe_raw & ~rst;
  assign sweep_set   = (state_q == ST_SWEEP && !rst) ? set_q : '0;
  assign busy        = (state_q != ST_IDLE);

`ifdef LLC_UPDATE_STARVE_GUARD_EN
  localparam int DEFER_W = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);
  localparam logic [DEFER_W-1:0] DEFER_MAX = DEFER_W'(MAX_DEFER);

  logic [DEFER_W-1:0] defer_q, defer_d;
  logic               deferring;

  // A pending plain update or sweep write is losing the port this cycle.
  assign deferring = rd_conflict &&
                     ((state_q == ST_IDLE && !fifo_empty_update && !head_special) ||
                      (state_q == ST_SWEEP));

  // Saturating count of consecutive deferred cycles; cleared on any port use.
  always_comb begin
    defer_d = defer_q;
    if (upd_raw || swe_raw) begin
      defer_d = '0;
    end else if (deferring && defer_q != DEFER_MAX) begin
      defer_d = defer_q + 1'b1;
    end
  end

  // Defer counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      defer_q <= '0;
    end else begin
      defer_q <= defer_d;
    end
  end

  // Ask the lookup stage to drop its request once the budget is exhausted.
  assign hold_lookup = !rst && deferring && (defer_q == DEFER_MAX);
`else
  // Without the guard, deferral is unbounded and the lookup stage is never held.
  assign hold_lookup = 1'b0;
`endif

endmodule

// File: tb/tb_llc_update_ctrl.sv
// Directed testbench for llc_update_ctrl (SET_BITS=4, MAX_DEFER=7).
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge. Works for both the default and the guard build.
module tb_llc_update_ctrl;

  localparam int SET_BITS = 4;
`ifdef LLC_UPDATE_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                fifo_empty_update;
  logic                head_is_rst;
  logic                head_is_flush;
  logic                rd_conflict;
  logic                llc_rst_tb_done_ready_int;
  logic                update_en;
  logic                sweep_wr_en;
  logic [SET_BITS-1:0] sweep_set;
  logic                busy;
  logic                hold_lookup;

  int checks = 0;
  int errors = 0;

  llc_update_ctrl #(.SET_BITS(SET_BITS), .MAX_DEFER(7)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .fifo_empty_update         (fifo_empty_update),
    .head_is_rst               (head_is_rst),
    .head_is_flush             (head_is_flush),
    .rd_conflict               (rd_conflict),
    .llc_rst_tb_done_ready_int (llc_rst_tb_done_ready_int),
    .update_en                 (update_en),
    .sweep_wr_en               (sweep_wr_en),
    .sweep_set                 (sweep_set),
    .busy                      (busy),
    .hold_lookup               (hold_lookup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected end before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Check all outputs on the falling edge, then advance to just past the next rising edge.
  task automatic expect_cyc(input string tag, input logic e_upd, input logic e_swe,
                            input logic [SET_BITS-1:0] e_set, input logic e_busy,
                            input logic e_hold);
    @(negedge clk);
    check({tag, ".update_en"},   32'(update_en),   32'(e_upd));
    check({tag, ".sweep_wr_en"}, 32'(sweep_wr_en), 32'(e_swe));
    check({tag, ".sweep_set"},   32'(sweep_set),   32'(e_set));
    check({tag, ".busy"},        32'(busy),        32'(e_busy));
    check({tag, ".hold_lookup"}, 32'(hold_lookup), 32'(e_hold));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic                conf;
    logic [SET_BITS-1:0] exp_set;

    rst                       = 1'b1;
    fifo_empty_update         = 1'b0;
    head_is_rst               = 1'b0;
    head_is_flush             = 1'b0;
    rd_conflict               = 1'b0;
    llc_rst_tb_done_ready_int = 1'b1;
    @(posedge clk);
    #1;

    // Reset held for two cycles with a plain head waiting: nothing fires.
    expect_cyc("reset0", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_cyc("reset1", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst               = 1'b0;
    fifo_empty_update = 1'b1;
    expect_cyc("post_reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Three plain heads back to back: update_en every cycle, never busy.
    fifo_empty_update = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_cyc($sformatf("plain%0d", i), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    end

    // Flush sweep with conflicts on sweep cycles 5 and 6 (20 cycles total).
    head_is_flush = 1'b1;
    expect_cyc("flush.idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int s = 0; s < 18; s++) begin
      conf        = (s == 5) || (s == 6);
      rd_conflict = conf;
      exp_set     = (s < 5) ? SET_BITS'(s) : ((s < 7) ? 4'd5 : SET_BITS'(s - 2));
      expect_cyc($sformatf("flush.sweep%0d", s), 1'b0, !conf, exp_set, 1'b1, 1'b0);
    end
    rd_conflict = 1'b0;
    expect_cyc("flush.finish", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    head_is_flush     = 1'b0;
    fifo_empty_update = 1'b1;
    expect_cyc("flush.idle_after", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Reset packet with done-channel backpressure for 10 cycles.
    fifo_empty_update         = 1'b0;
    head_is_rst               = 1'b1;
    llc_rst_tb_done_ready_int = 1'b0;
    expect_cyc("bp.idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int s = 0; s < 16; s++) begin
      expect_cyc($sformatf("bp.sweep%0d", s), 1'b0, 1'b1, SET_BITS'(s), 1'b1, 1'b0);
    end
    for (int w = 0; w < 10; w++) begin
      expect_cyc($sformatf("bp.wait%0d", w), 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    end
    llc_rst_tb_done_ready_int = 1'b1;
    expect_cyc("bp.fire", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    head_is_rst       = 1'b0;
    fifo_empty_update = 1'b1;
    expect_cyc("bp.idle_after", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Reset in the middle of a flush sweep, then the same head restarts at set 0.
    fifo_empty_update = 1'b0;
    head_is_flush     = 1'b1;
    expect_cyc("mid.idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int s = 0; s < 9; s++) begin
      expect_cyc($sformatf("mid.sweep%0d", s), 1'b0, 1'b1, SET_BITS'(s), 1'b1, 1'b0);
    end
    rst = 1'b1;
    expect_cyc("mid.rst_cycle", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    rst = 1'b0;
    expect_cyc("mid.after_rst", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int s = 0; s < 16; s++) begin
      expect_cyc($sformatf("mid.resweep%0d", s), 1'b0, 1'b1, SET_BITS'(s), 1'b1, 1'b0);
    end
    expect_cyc("mid.finish", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    head_is_flush     = 1'b0;
    fifo_empty_update = 1'b1;
    expect_cyc("mid.idle_after", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Starvation: plain head with rd_conflict held for 8 cycles; the guard
    // build raises hold_lookup on the 8th, the default build never does.
    fifo_empty_update = 1'b0;
    rd_conflict       = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      expect_cyc($sformatf("starve%0d", k), 1'b0, 1'b0, 4'd0, 1'b0,
                 GUARD && (k == 8));
    end
    rd_conflict = 1'b0;
    expect_cyc("starve.release", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    fifo_empty_update = 1'b1;
    expect_cyc("starve.idle_after", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
